// File: rtl/img_pkg.sv
// Shared types and constants for the frame write arbiter.
// Pixel pairs are packed as {R0,G0,B0,R1,G1,B1}, with 8 bits per channel.
package img_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } fwa_state_t;

  localparam int PIX_PAIR_W = 48;
  localparam int CH_W       = 8;

  localparam int R0_LSB = 40;
  localparam int G0_LSB = 32;
  localparam int B0_LSB = 24;
  localparam int R1_LSB = 16;
  localparam int G1_LSB = 8;
  localparam int B1_LSB = 0;

  // Build one pair word from its six channel bytes.
  function automatic logic [PIX_PAIR_W-1:0] pack_pair(
    input logic [CH_W-1:0] r0, input logic [CH_W-1:0] g0, input logic [CH_W-1:0] b0,
    input logic [CH_W-1:0] r1, input logic [CH_W-1:0] g1, input logic [CH_W-1:0] b1);
    logic [PIX_PAIR_W-1:0] w;
    w = '0;
    w[R0_LSB +: CH_W] = r0;
    w[G0_LSB +: CH_W] = g0;
    w[B0_LSB +: CH_W] = b0;
    w[R1_LSB +: CH_W] = r1;
    w[G1_LSB +: CH_W] = g1;
    w[B1_LSB +: CH_W] = b1;
    return w;
  endfunction

endpackage

// File: rtl/frame_write_arbiter_if.sv
// Bundles the producer handshakes and the image-writer side of the frame write arbiter.
// The slave modport belongs to the arbiter; the master modport belongs to the producers and the writer.
interface frame_write_arbiter_if #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
);
  import img_pkg::*;

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH / 2);

  logic                  req0;
  logic                  req1;
  logic                  pix_valid0;
  logic                  pix_valid1;
  logic [PIX_PAIR_W-1:0] pix_data0;
  logic [PIX_PAIR_W-1:0] pix_data1;
  logic                  pix_ready0;
  logic                  pix_ready1;
  logic                  wr_hsync;
  logic [PIX_PAIR_W-1:0] wr_data;
  logic [ROW_W-1:0]      wr_row;
  logic [COL_W-1:0]      wr_col;
  logic [1:0]            grant;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output req0, req1, pix_valid0, pix_valid1, pix_data0, pix_data1,
    input  pix_ready0, pix_ready1, wr_hsync, wr_data, wr_row, wr_col,
           grant, busy, frame_done
  );

  modport slave (
    input  req0, req1, pix_valid0, pix_valid1, pix_data0, pix_data1,
    output pix_ready0, pix_ready1, wr_hsync, wr_data, wr_row, wr_col,
           grant, busy, frame_done
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. A lone request always wins.
// When both requesters ask, the one that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot pick; on a tie, the requester other than 'last' wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Frame write arbiter: grants the single frame-write port to one of two
// pixel-pair producers for one whole frame. Frames are granted round-robin.
// Optional macro FWA_BLANK_INSERT_EN inserts H_BLANK ready-low cycles after every
// line except the last. When the macro is undefined, lines run back to back.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// XFER  | owner may transfer one pair per cycle
// BLANK | inter-line gap, ready held low
// DONE  | last pair written; frame_done high, release owner
module frame_write_arbiter
  import img_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int H_BLANK = 4
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  frame_write_arbiter_if.slave bus
);

  localparam int PAIRS = WIDTH / 2;
  localparam int COL_W = $clog2(PAIRS);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int BLK_W = $clog2(H_BLANK + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAIRS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  fwa_state_t            state;
  logic [ROW_W-1:0]      row_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic [BLK_W-1:0]      blank_cnt;
  logic                  last_served;
  logic [1:0]            grant_q;
  logic                  busy_q;
  logic                  wr_hsync_q;
  logic [PIX_PAIR_W-1:0] wr_data_q;
  logic [ROW_W-1:0]      wr_row_q;
  logic [COL_W-1:0]      wr_col_q;
  logic                  frame_done_q;

  logic [1:0]            pick;
  logic                  beat;
  logic                  col_end;
  logic                  frame_end;
  logic [PIX_PAIR_W-1:0] own_data;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.req1, bus.req0}),
    .last (last_served),
    .gnt  (pick)
  );

  // Ready depends only on registered state, so there is no path from valid to ready.
  assign bus.pix_ready0 = (state == XFER) & grant_q[0];
  assign bus.pix_ready1 = (state == XFER) & grant_q[1];

  assign beat      = (bus.pix_ready0 & bus.pix_valid0) | (bus.pix_ready1 & bus.pix_valid1);
  assign own_data  = grant_q[1] ? bus.pix_data1 : bus.pix_data0;
  assign col_end   = (col_cnt == COL_LAST);
  assign frame_end = col_end & (row_cnt == ROW_LAST);

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.wr_hsync   = wr_hsync_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.frame_done = frame_done_q;

  // Frame sequencer, pair counters and registered writer outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      row_cnt      <= '0;
      col_cnt      <= '0;
      blank_cnt    <= '0;
      last_served  <= 1'b1;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      wr_hsync_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_hsync_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            wr_hsync_q <= 1'b1;
            wr_data_q  <= own_data;
            wr_row_q   <= row_cnt;
            wr_col_q   <= col_cnt;
            if (frame_end) begin
              frame_done_q <= 1'b1;
              row_cnt      <= '0;
              col_cnt      <= '0;
              state        <= DONE;
            end else if (col_end) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
`ifdef FWA_BLANK_INSERT_EN
              blank_cnt <= BLK_W'(H_BLANK - 1);
              state     <= BLANK;
`endif
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        BLANK: begin
          if (blank_cnt == '0) begin
            state <= XFER;
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        DONE: begin
          last_served <= grant_q[1];
          grant_q     <= 2'b00;
          busy_q      <= 1'b0;
          row_cnt     <= '0;
          col_cnt     <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
